uart_tx_fifo: RTL and testbench

Parametrised, buffered UART transmitter. It replaces the single-byte transmit path with a configurable frame format (data bits, parity, stop bits) and an internal FIFO, so firmware or test logic can queue several characters to the ESP32 link without waiting on each one. It sits between the board-level byte source (switches, keypad or a future bus) and the serial pin. Frames go out back-to-back while the FIFO holds data.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 80 ++++++++
 rtl/uart_tx_fifo.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit/receive paths.
// Holds the transmitter state encoding, parity-mode selectors, the default
// baud divider for a 50 MHz clock at 115200 baud, and a parity helper.
package uart_pkg;

  // 50 MHz / 115200 baud, rounded to the nearest whole clock count.
  localparam int CLKS_PER_BIT_115200 = 434;

  // Parity-mode selectors used by the PARITY parameter.
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Transmitter FSM states, in the order a frame walks through them.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Turns the XOR of the data bits into the parity bit for the given mode:
  // even parity sends the XOR itself, odd parity sends its inverse.
  function automatic logic parity_bit(input logic data_xor, input int mode);
    return (mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty/level flags and a
// sticky overflow flag. The head entry is always visible on rd_data
// (show-ahead), so a consumer can load it in the same cycle it pops.
// Full is judged on the registered level, so a pop in the same cycle does
// not open a slot for a write while full. Shared by the TX and RX paths.
// Reset: rst is asynchronous and active low.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_n;
  logic             full_q;
  logic             empty_q;
  logic             overflow_q;
  logic             push;
  logic             pop;

  assign push = wr_en && !full_q;
  assign pop  = rd_en && !empty_q;

  // Next occupancy: a simultaneous push and pop leaves the level unchanged.
  always_comb begin
    level_n = level_q;
    case ({push, pop})
      2'b10:   level_n = level_q + LW'(1);
      2'b01:   level_n = level_q - LW'(1);
      default: level_n = level_q;
    endcase
  end

  // Pointers, occupancy and flags; flags are registered from the next level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_n;
      full_q  <= (level_n == LW'(DEPTH));
      empty_q <= (level_n == '0);
      if (wr_en && full_q) overflow_q <= 1'b1;
    end
  end

  // Storage array; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = mem[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with configurable frame format
// (DATA_BITS data bits, optional odd/even parity, 1 or 2 stop bits) fed by an
// internal sync_fifo. Frames are sent back-to-back while the FIFO holds data.
// Every output is registered; the line value is computed for the state being
// entered so it changes on the same edge as the state.
// Optional build macro UART_TX_CTS_EN adds the active-low i_cts_n input: it is
// synchronised through two flops and gates only the start of a frame.
// Reset: rst is asynchronous and active low; a reset mid-frame drops the frame
// and all queued data.
//
// Handshake: the write side has no backpressure signal; a write is accepted
// on any edge where i_wr_en is high and o_full is low, otherwise it is dropped
// and o_overflow latches until reset.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_wr_en,
  input  logic [DATA_BITS-1:0]        i_wr_data,
`ifdef UART_TX_CTS_EN
  input  logic                        i_cts_n,
`endif
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_overflow,
  output logic                        o_tx_serial,
  output logic                        o_tx_active,
  output logic                        o_tx_done,
  output tx_state_t                   o_dbg_state
);

  // The PARITY parameter shadows the package's PARITY state name inside this
  // module, so that state is always written as uart_pkg::PARITY here.
  localparam int                BAUD_W     = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST  = 4'(STOP_BITS - 1);
  localparam bit                HAS_PARITY = (PARITY != PARITY_NONE);

  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 cts_ok;
  logic                 can_start;

  tx_state_t            state_q;
  tx_state_t            state_n;
  logic [BAUD_W-1:0]    baud_q;
  logic [BAUD_W-1:0]    baud_n;
  logic [3:0]           bit_q;
  logic [3:0]           bit_n;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_n;
  logic                 par_q;
  logic                 par_n;
  logic                 baud_end;
  logic                 start_frame;
  logic                 line_n;
  logic                 done_n;
  logic                 tx_serial_q;
  logic                 tx_active_q;
  logic                 tx_done_q;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (i_wr_en),
    .wr_data  (i_wr_data),
    .rd_en    (fifo_pop),
    .rd_data  (fifo_rd_data),
    .full     (o_full),
    .empty    (fifo_empty),
    .level    (o_level),
    .overflow (o_overflow)
  );

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync_q;

  // Two-flop synchroniser for the asynchronous clear-to-send input; resets to
  // "not clear" so nothing starts before the pin has been sampled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cts_sync_q <= 2'b11;
    else      cts_sync_q <= {cts_sync_q[0], i_cts_n};
  end

  assign cts_ok = !cts_sync_q[1];
`else
  assign cts_ok = 1'b1;
`endif

  assign can_start = !fifo_empty && cts_ok;
  assign baud_end  = (baud_q == BAUD_LAST);

  // Next-state logic: bit timing, bit/stop counting, shifting, and frame
  // start (pop + load) from IDLE or directly out of the last stop bit.
  always_comb begin
    state_n     = state_q;
    baud_n      = baud_q;
    bit_n       = bit_q;
    shift_n     = shift_q;
    par_n       = par_q;
    done_n      = 1'b0;
    start_frame = 1'b0;
    fifo_pop    = 1'b0;
    line_n      = 1'b1;

    case (state_q)
      IDLE: begin
        start_frame = can_start;
      end
      START: begin
        if (baud_end) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n = '0;
          if (bit_q == DATA_LAST) begin
            bit_n   = '0;
            state_n = HAS_PARITY ? uart_pkg::PARITY : STOP;
          end else begin
            bit_n   = bit_q + 4'(1);
            shift_n = shift_q >> 1;
          end
        end else begin
          baud_n = baud_q + BAUD_W'(1);
        end
      end
      uart_pkg::PARITY: begin
        if (baud_end) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = STOP;
        end else begin
          baud_n = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_n = '0;
          if (bit_q == STOP_LAST) begin
            done_n      = 1'b1;
            bit_n       = '0;
            state_n     = IDLE;
            start_frame = can_start;
          end else begin
            bit_n = bit_q + 4'(1);
          end
        end else begin
          baud_n = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Frame start overrides whatever the state above decided.
    if (start_frame) begin
      fifo_pop = 1'b1;
      shift_n  = fifo_rd_data;
      par_n    = parity_bit(^fifo_rd_data, PARITY);
      baud_n   = '0;
      bit_n    = '0;
      state_n  = START;
    end

    // Line level for the state being entered.
    case (state_n)
      START:            line_n = 1'b0;
      DATA:             line_n = shift_n[0];
      uart_pkg::PARITY: line_n = par_n;
      default:          line_n = 1'b1;
    endcase
  end

  // FSM state, counters, datapath and registered line outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tx_serial_q <= 1'b1;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_n;
      baud_q      <= baud_n;
      bit_q       <= bit_n;
      shift_q     <= shift_n;
      par_q       <= par_n;
      tx_serial_q <= line_n;
      tx_active_q <= (state_n != IDLE);
      tx_done_q   <= done_n;
    end
  end

  assign o_empty     = fifo_empty;
  assign o_tx_serial = tx_serial_q;
  assign o_tx_active = tx_active_q;
  assign o_tx_done   = tx_done_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo at CLKS_PER_BIT=4.
// Four instances cover 8N1 (depth 4), 8E1, 8O1 and 7E2 frame formats.
// A vector table holds single-frame cases with hand-computed line patterns;
// hand-written sequences cover back-to-back frames, overflow, mid-frame reset
// and (when UART_TX_CTS_EN is defined) clear-to-send gating.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int CPB  = 4;
  localparam int NDUT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cts_n;
  logic       wr_en   [NDUT];
  logic [7:0] wr_data [NDUT];
  logic       serial  [NDUT];
  logic       active  [NDUT];
  logic       done    [NDUT];
  logic       full    [NDUT];
  logic       empty   [NDUT];
  logic       ovf     [NDUT];
  logic [2:0] level   [NDUT];
  tx_state_t  st      [NDUT];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          sel;
    logic [7:0]  data;
    int          nbits;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [8];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_NONE),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_8n1 (
    .clk(clk), .rst(rst), .i_wr_en(wr_en[0]), .i_wr_data(wr_data[0]),
`ifdef UART_TX_CTS_EN
    .i_cts_n(cts_n),
`endif
    .o_full(full[0]), .o_empty(empty[0]), .o_level(level[0]), .o_overflow(ovf[0]),
    .o_tx_serial(serial[0]), .o_tx_active(active[0]), .o_tx_done(done[0]),
    .o_dbg_state(st[0])
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_EVEN),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_8e1 (
    .clk(clk), .rst(rst), .i_wr_en(wr_en[1]), .i_wr_data(wr_data[1]),
`ifdef UART_TX_CTS_EN
    .i_cts_n(cts_n),
`endif
    .o_full(full[1]), .o_empty(empty[1]), .o_level(level[1]), .o_overflow(ovf[1]),
    .o_tx_serial(serial[1]), .o_tx_active(active[1]), .o_tx_done(done[1]),
    .o_dbg_state(st[1])
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_ODD),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_8o1 (
    .clk(clk), .rst(rst), .i_wr_en(wr_en[2]), .i_wr_data(wr_data[2]),
`ifdef UART_TX_CTS_EN
    .i_cts_n(cts_n),
`endif
    .o_full(full[2]), .o_empty(empty[2]), .o_level(level[2]), .o_overflow(ovf[2]),
    .o_tx_serial(serial[2]), .o_tx_active(active[2]), .o_tx_done(done[2]),
    .o_dbg_state(st[2])
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PARITY_EVEN),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) dut_7e2 (
    .clk(clk), .rst(rst), .i_wr_en(wr_en[3]), .i_wr_data(wr_data[3][6:0]),
`ifdef UART_TX_CTS_EN
    .i_cts_n(cts_n),
`endif
    .o_full(full[3]), .o_empty(empty[3]), .o_level(level[3]), .o_overflow(ovf[3]),
    .o_tx_serial(serial[3]), .o_tx_active(active[3]), .o_tx_done(done[3]),
    .o_dbg_state(st[3])
  );

  // ---------------- driver / checker tasks ----------------
  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Queue one character into an idle instance and capture its frame at
  // mid-bit, checking start timing and the single done pulse at frame end.
  task automatic run_vector(input int idx, input vec_t v);
    logic [11:0] got;
    int          early_done;
    int          ncyc;
    got        = '0;
    early_done = 0;
    ncyc       = v.nbits * CPB;
    wr_data[v.sel] = v.data;
    wr_en[v.sel]   = 1'b1;
    tick();                                    // write edge k
    wr_en[v.sel] = 1'b0;
    check($sformatf("v%0d_empty_fall", idx), 32'(empty[v.sel]), 32'd0);
    tick();                                    // pop edge k+1
    check($sformatf("v%0d_start", idx), 32'({active[v.sel], serial[v.sel]}), 32'b10);
    for (int t = 0; t < ncyc; t++) begin
      if (t % CPB == 2) got[t / CPB] = serial[v.sel];
      if (done[v.sel]) early_done++;
      tick();
    end
    check($sformatf("v%0d_frame", idx), 32'(got), 32'(v.exp));
    check($sformatf("v%0d_no_early_done", idx), 32'(early_done), 32'd0);
    check($sformatf("v%0d_done_end", idx), 32'({done[v.sel], active[v.sel], serial[v.sel]}), 32'b101);
    tick();
    check($sformatf("v%0d_done_clear", idx), 32'(done[v.sel]), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [29:0] got30;
    int          act_cnt;
    int          done_cnt;
    int          low_cnt;
    logic        e79;
    logic        e80;
    logic        d40;
    logic        s40;

    // Frame patterns listed as {stop(s), parity, data, start}; bit 0 is first on the line.
    vecs[0] = '{0, 8'hA5, 10, {2'b00, 1'b1, 8'hA5, 1'b0}};
    vecs[1] = '{0, 8'h3C, 10, {2'b00, 1'b1, 8'h3C, 1'b0}};
    vecs[2] = '{1, 8'hA5, 11, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}};   // 4 ones: even -> 0
    vecs[3] = '{1, 8'h07, 11, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}};   // 3 ones: even -> 1
    vecs[4] = '{2, 8'h01, 11, {1'b0, 1'b1, 1'b0, 8'h01, 1'b0}};   // 1 one : odd  -> 0
    vecs[5] = '{2, 8'h00, 11, {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}};   // 0 ones: odd  -> 1
    vecs[6] = '{3, 8'h5A, 11, {1'b0, 2'b11, 1'b0, 7'h5A, 1'b0}};  // 4 ones: even -> 0
    vecs[7] = '{3, 8'h7F, 11, {1'b0, 2'b11, 1'b1, 7'h7F, 1'b0}};  // 7 ones: even -> 1

    rst   = 1'b0;
    cts_n = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      wr_en[i]   = 1'b0;
      wr_data[i] = '0;
    end

    // Reset values
    repeat (3) tick();
    check("rst_serial",   32'(serial[0]), 32'd1);
    check("rst_active",   32'(active[0]), 32'd0);
    check("rst_done",     32'(done[0]),   32'd0);
    check("rst_empty",    32'(empty[0]),  32'd1);
    check("rst_full",     32'(full[0]),   32'd0);
    check("rst_level",    32'(level[0]),  32'd0);
    check("rst_overflow", 32'(ovf[0]),    32'd0);
    check("rst_state",    32'(st[0]),     32'(IDLE));
    rst = 1'b1;
    repeat (4) tick();

    // Table-driven single frames
    for (int i = 0; i < 8; i++) begin
      run_vector(i, vecs[i]);
      tick();
    end

    // Back-to-back: 0x11, 0x22, 0x33 on consecutive cycles
    got30    = '0;
    act_cnt  = 0;
    done_cnt = 0;
    e79 = 1'bx; e80 = 1'bx; d40 = 1'bx; s40 = 1'bx;
    wr_data[0] = 8'h11; wr_en[0] = 1'b1;
    tick();                                    // edge k
    wr_data[0] = 8'h22;
    tick();                                    // edge k+1: t = 0
    for (int t = 0; t < 130; t++) begin
      if (t == 0) wr_data[0] = 8'h33;
      if (t == 1) wr_en[0] = 1'b0;
      if (active[0]) act_cnt++;
      if (done[0]) done_cnt++;
      if (t < 120 && t % CPB == 2) got30[t / CPB] = serial[0];
      if (t == 40) begin d40 = done[0]; s40 = serial[0]; end
      if (t == 79) e79 = empty[0];
      if (t == 80) e80 = empty[0];
      tick();
    end
    check("b2b_frames", 32'(got30),
          32'({1'b1, 8'h33, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0}));
    check("b2b_active_cycles", 32'(act_cnt), 32'd120);
    check("b2b_done_pulses", 32'(done_cnt), 32'd3);
    check("b2b_done_with_start", 32'({d40, s40}), 32'b10);
    check("b2b_empty_before_pop3", 32'(e79), 32'd0);
    check("b2b_empty_at_pop3", 32'(e80), 32'd1);

    // Overflow: one frame in flight, then 6 writes into a depth-4 FIFO
    wr_data[0] = 8'h41; wr_en[0] = 1'b1;
    tick();                                    // edge k
    wr_en[0] = 1'b0;
    tick();                                    // edge k+1: frame starts
    check("ovf_inflight", 32'(active[0]), 32'd1);
    for (int i = 0; i < 6; i++) begin
      wr_data[0] = 8'h50 + 8'(i);
      wr_en[0]   = 1'b1;
      tick();
      if (i == 3) begin
        check("ovf_full_at_4", 32'({full[0], level[0]}), 32'({1'b1, 3'd4}));
        check("ovf_not_yet", 32'(ovf[0]), 32'd0);
      end
    end
    wr_en[0] = 1'b0;
    check("ovf_full", 32'(full[0]), 32'd1);
    check("ovf_level", 32'(level[0]), 32'd4);
    check("ovf_flag", 32'(ovf[0]), 32'd1);
    done_cnt = 0;
    for (int t = 0; t < 400; t++) begin
      if (done[0]) done_cnt++;
      tick();
    end
    check("ovf_frames_sent", 32'(done_cnt), 32'd5);
    check("ovf_drained", 32'({empty[0], level[0], active[0]}), 32'({1'b1, 3'd0, 1'b0}));
    check("ovf_sticky", 32'(ovf[0]), 32'd1);

    // Reset in the middle of DATA bit 2 with one more byte queued
    wr_data[0] = 8'h00; wr_en[0] = 1'b1;
    tick();                                    // edge k
    tick();                                    // edge k+1: pop + second push
    wr_en[0] = 1'b0;
    repeat (14) tick();                        // t = 14, mid DATA bit 2
    check("mid_pre_line", 32'({active[0], serial[0]}), 32'b10);
    check("mid_pre_level", 32'(level[0]), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_serial", 32'(serial[0]), 32'd1);
    check("mid_rst_active", 32'(active[0]), 32'd0);
    check("mid_rst_fifo", 32'({empty[0], level[0], ovf[0]}), 32'({1'b1, 3'd0, 1'b0}));
    tick();
    tick();
    rst = 1'b1;
    done_cnt = 0;
    low_cnt  = 0;
    act_cnt  = 0;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (done[0]) done_cnt++;
      if (!serial[0]) low_cnt++;
      if (active[0]) act_cnt++;
    end
    check("post_rst_done", 32'(done_cnt), 32'd0);
    check("post_rst_line_low", 32'(low_cnt), 32'd0);
    check("post_rst_active", 32'(act_cnt), 32'd0);

`ifdef UART_TX_CTS_EN
    // Clear-to-send gating at frame start only
    cts_n = 1'b1;
    repeat (3) tick();
    wr_data[0] = 8'h55; wr_en[0] = 1'b1;
    tick();
    wr_en[0] = 1'b0;
    low_cnt = 0;
    act_cnt = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (!serial[0]) low_cnt++;
      if (active[0]) act_cnt++;
    end
    check("cts_hold_line", 32'(low_cnt), 32'd0);
    check("cts_hold_active", 32'(act_cnt), 32'd0);
    check("cts_hold_level", 32'(level[0]), 32'd1);
    cts_n = 1'b0;
    tick();                                    // edge m
    check("cts_lat1", 32'(serial[0]), 32'd1);
    tick();                                    // edge m+1
    check("cts_lat2", 32'(serial[0]), 32'd1);
    tick();                                    // edge m+2: start bit
    check("cts_start", 32'({active[0], serial[0]}), 32'b10);
    done_cnt = 0;
    for (int t = 0; t < 40; t++) begin
      if (t == 10) cts_n = 1'b1;
      if (done[0]) done_cnt++;
      tick();
    end
    check("cts_frame_done", 32'({done[0], active[0], serial[0]}), 32'b101);
    check("cts_no_early_done", 32'(done_cnt), 32'd0);
    cts_n = 1'b0;
    repeat (4) tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
